// File: rtl/panel_serial_io.sv
// Serial front-panel transport: shifts four 16-bit 74LV595 display chains out
// while reading four 16-bit 74LV165 switch chains in, one frame after another.
module panel_serial_io #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [30:0] pnl_reg_c_value,
    input  logic [5:0]  pnl_op_code,
    input  logic [11:0] pnl_strt_value,
    input  logic [11:0] pnl_sel_value,
    output logic        serial_out_srclk,
    output logic        serial_out_rclk,
    output logic        serial_out_ser_0,
    output logic        serial_out_ser_1,
    output logic        serial_out_ser_2,
    output logic        serial_out_ser_3,
    output logic        serial_in_rclk,
    output logic        serial_in_shldn,
    input  logic        serial_in_ser_0,
    input  logic        serial_in_ser_1,
    input  logic        serial_in_ser_2,
    input  logic        serial_in_ser_3,
    output logic [30:0] sw_arr_reg_c_value,
    output logic [11:0] sw_arr_strt_value,
    output logic [11:0] sw_arr_sel_value,
    output logic        sw_valid,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH
    } state_t;

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    // Display lanes as they go onto the 595 chains, MSB shifted first.
    function automatic logic [3:0][15:0] pack_lanes(
        input logic [30:0] reg_c,
        input logic [5:0]  op_code,
        input logic [11:0] strt,
        input logic [11:0] sel
    );
        logic [29:0]      v;
        logic [3:0][15:0] lanes;
        v        = {op_code, strt, sel};
        lanes[0] = reg_c[15:0];
        lanes[1] = {1'b0, reg_c[30:16]};
        lanes[2] = v[15:0];
        lanes[3] = {2'b0, v[29:16]};
        return lanes;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             half_q, half_d;   // 0 = half A, 1 = half B
    logic [3:0]       bit_q, bit_d;
    logic [3:0][15:0] out_sr_q, out_sr_d;

    // Input shifters keep only the bits that survive; discarded bits fall off the top.
    logic [15:0] in0_q, in0_d;
    logic [14:0] in1_q, in1_d;
    logic [15:0] in2_q, in2_d;
    logic [7:0]  in3_q, in3_d;

    logic [30:0] sw_reg_c_q, sw_reg_c_d;
    logic [11:0] sw_strt_q, sw_strt_d;
    logic [11:0] sw_sel_q, sw_sel_d;
    logic        sw_valid_q, sw_valid_d;
    logic        frame_done_q, frame_done_d;

    logic        srclk_q, srclk_d;
    logic        rclk_q, rclk_d;
    logic        in_rclk_q, in_rclk_d;
    logic        shldn_q, shldn_d;
    logic [3:0]  ser_q, ser_d;

    logic        half_end;
    logic [3:0]  ser_in;

    assign half_end = (cnt_q == CNT_LAST);
    assign ser_in   = {serial_in_ser_3, serial_in_ser_2, serial_in_ser_1, serial_in_ser_0};

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = half_end ? '0 : cnt_q + CW'(1);
        half_d       = half_q;
        bit_d        = bit_q;
        out_sr_d     = out_sr_q;
        in0_d        = in0_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        in3_d        = in3_q;
        sw_reg_c_d   = sw_reg_c_q;
        sw_strt_d    = sw_strt_q;
        sw_sel_d     = sw_sel_q;
        sw_valid_d   = sw_valid_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d  = S_LOAD;
                cnt_d    = '0;
                half_d   = 1'b0;
                out_sr_d = pack_lanes(pnl_reg_c_value, pnl_op_code,
                                      pnl_strt_value, pnl_sel_value);
            end
            S_LOAD: begin
                if (half_end) begin
                    half_d = ~half_q;
                    if (half_q) begin
                        state_d = S_SHIFT;
                        bit_d   = '0;
                    end
                end
            end
            S_SHIFT: begin
                if (half_end) begin
                    half_d = ~half_q;
                    if (!half_q) begin
                        // End of half A: the 165 QH outputs are settled here.
                        in0_d = {in0_q[14:0], ser_in[0]};
                        in1_d = {in1_q[13:0], ser_in[1]};
                        in2_d = {in2_q[14:0], ser_in[2]};
                        in3_d = {in3_q[6:0],  ser_in[3]};
                    end else begin
                        for (int n = 0; n < 4; n++) begin
                            out_sr_d[n] = {out_sr_q[n][14:0], 1'b0};
                        end
                        if (bit_q == 4'd15) begin
                            state_d = S_LATCH;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end
            S_LATCH: begin
                if (half_end) begin
                    half_d = ~half_q;
                    if (half_q) begin
                        state_d      = S_LOAD;
                        out_sr_d     = pack_lanes(pnl_reg_c_value, pnl_op_code,
                                                  pnl_strt_value, pnl_sel_value);
                        sw_reg_c_d   = {in1_q, in0_q};
                        sw_strt_d    = {in3_q, in2_q[15:12]};
                        sw_sel_d     = in2_q[11:0];
                        sw_valid_d   = 1'b1;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pin levels are decoded from the next state so the flops line up with the phase.
        srclk_d   = (state_d == S_SHIFT) && half_d;
        in_rclk_d = (state_d == S_SHIFT) && half_d;
        rclk_d    = (state_d == S_LATCH) && half_d;
        shldn_d   = (state_d != S_LOAD);
        for (int n = 0; n < 4; n++) begin
            ser_d[n] = (state_d == S_SHIFT) ? out_sr_d[n][15] : 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before this edge regardless of block order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            half_q       <= 1'b0;
            bit_q        <= '0;
            out_sr_q     <= '0;
            in0_q        <= '0;
            in1_q        <= '0;
            in2_q        <= '0;
            in3_q        <= '0;
            sw_reg_c_q   <= '0;
            sw_strt_q    <= '0;
            sw_sel_q     <= '0;
            sw_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            srclk_q      <= 1'b0;
            rclk_q       <= 1'b0;
            in_rclk_q    <= 1'b0;
            shldn_q      <= 1'b1;
            ser_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            bit_q        <= bit_d;
            out_sr_q     <= out_sr_d;
            in0_q        <= in0_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            in3_q        <= in3_d;
            sw_reg_c_q   <= sw_reg_c_d;
            sw_strt_q    <= sw_strt_d;
            sw_sel_q     <= sw_sel_d;
            sw_valid_q   <= sw_valid_d;
            frame_done_q <= frame_done_d;
            srclk_q      <= srclk_d;
            rclk_q       <= rclk_d;
            in_rclk_q    <= in_rclk_d;
            shldn_q      <= shldn_d;
            ser_q        <= ser_d;
        end
    end

    assign serial_out_srclk   = srclk_q;
    assign serial_out_rclk    = rclk_q;
    assign serial_out_ser_0   = ser_q[0];
    assign serial_out_ser_1   = ser_q[1];
    assign serial_out_ser_2   = ser_q[2];
    assign serial_out_ser_3   = ser_q[3];
    assign serial_in_rclk     = in_rclk_q;
    assign serial_in_shldn    = shldn_q;
    assign sw_arr_reg_c_value = sw_reg_c_q;
    assign sw_arr_strt_value  = sw_strt_q;
    assign sw_arr_sel_value   = sw_sel_q;
    assign sw_valid           = sw_valid_q;
    assign frame_done         = frame_done_q;

endmodule

// File: tb/tb_panel_serial_io.sv
// Bench for panel_serial_io: 595/165 chain models on a CLK_DIV=4 instance,
// frame period and clock phase checks on a CLK_DIV=1 instance.
module tb_panel_serial_io;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Shared display inputs.
    logic [30:0] pnl_reg_c;
    logic [5:0]  pnl_op;
    logic [11:0] pnl_strt;
    logic [11:0] pnl_sel;

    // ---------------- instance 0: CLK_DIV = 4, with chain models ----------------
    logic        rst0;
    logic        srclk0, rclk0, in_rclk0, shldn0, valid0, fd0;
    logic [3:0]  so0, si0;
    logic [30:0] sw_reg_c0;
    logic [11:0] sw_strt0, sw_sel0;

    panel_serial_io #(.CLK_DIV(4)) dut0 (
        .clk(clk), .resetn(rst0),
        .pnl_reg_c_value(pnl_reg_c), .pnl_op_code(pnl_op),
        .pnl_strt_value(pnl_strt), .pnl_sel_value(pnl_sel),
        .serial_out_srclk(srclk0), .serial_out_rclk(rclk0),
        .serial_out_ser_0(so0[0]), .serial_out_ser_1(so0[1]),
        .serial_out_ser_2(so0[2]), .serial_out_ser_3(so0[3]),
        .serial_in_rclk(in_rclk0), .serial_in_shldn(shldn0),
        .serial_in_ser_0(si0[0]), .serial_in_ser_1(si0[1]),
        .serial_in_ser_2(si0[2]), .serial_in_ser_3(si0[3]),
        .sw_arr_reg_c_value(sw_reg_c0), .sw_arr_strt_value(sw_strt0),
        .sw_arr_sel_value(sw_sel0), .sw_valid(valid0), .frame_done(fd0)
    );

    // 595 chains: shift on srclk, latch to display on rclk.
    logic [3:0][15:0] sh595, q595;
    always @(posedge srclk0)
        for (int n = 0; n < 4; n++) sh595[n] <= {sh595[n][14:0], so0[n]};
    always @(posedge rclk0) q595 <= sh595;

    logic [30:0] disp_reg_c;
    logic [29:0] disp_v;
    assign disp_reg_c = {q595[1][14:0], q595[0]};
    assign disp_v     = {q595[3][13:0], q595[2]};

    // 165 chains: parallel load while SH/LDn low, shift on CLK, QH = bit 15.
    logic [3:0][15:0] par165, sr165;
    always @(posedge in_rclk0 or negedge shldn0) begin
        if (!shldn0) sr165 <= par165;
        else for (int n = 0; n < 4; n++) sr165[n] <= {sr165[n][14:0], 1'b0};
    end
    always_comb for (int n = 0; n < 4; n++) si0[n] = sr165[n][15];

    int cyc0 = 0;
    int n_srclk0 = 0, n_rclk0 = 0, n_inclk0 = 0, srclk_at_rclk0 = 0;
    always @(posedge clk) cyc0 <= rst0 ? cyc0 + 1 : 0;
    always @(posedge srclk0) n_srclk0 <= n_srclk0 + 1;
    always @(posedge in_rclk0) n_inclk0 <= n_inclk0 + 1;
    always @(posedge rclk0) begin
        n_rclk0        <= n_rclk0 + 1;
        srclk_at_rclk0 <= n_srclk0;
    end

    // ---------------- instance 1: CLK_DIV = 1, constant switch lanes ----------------
    logic        rst1;
    logic        srclk1, rclk1, in_rclk1, shldn1, valid1, fd1;
    logic [3:0]  so1;
    logic [3:0]  si1 = 4'b0101;
    logic [30:0] sw_reg_c1;
    logic [11:0] sw_strt1, sw_sel1;

    panel_serial_io #(.CLK_DIV(1)) dut1 (
        .clk(clk), .resetn(rst1),
        .pnl_reg_c_value(pnl_reg_c), .pnl_op_code(pnl_op),
        .pnl_strt_value(pnl_strt), .pnl_sel_value(pnl_sel),
        .serial_out_srclk(srclk1), .serial_out_rclk(rclk1),
        .serial_out_ser_0(so1[0]), .serial_out_ser_1(so1[1]),
        .serial_out_ser_2(so1[2]), .serial_out_ser_3(so1[3]),
        .serial_in_rclk(in_rclk1), .serial_in_shldn(shldn1),
        .serial_in_ser_0(si1[0]), .serial_in_ser_1(si1[1]),
        .serial_in_ser_2(si1[2]), .serial_in_ser_3(si1[3]),
        .sw_arr_reg_c_value(sw_reg_c1), .sw_arr_strt_value(sw_strt1),
        .sw_arr_sel_value(sw_sel1), .sw_valid(valid1), .frame_done(fd1)
    );

    int cyc1 = 0, n_srclk1 = 0, n_hi1 = 0;
    always @(posedge clk) cyc1 <= rst1 ? cyc1 + 1 : 0;
    always @(posedge srclk1) n_srclk1 <= n_srclk1 + 1;
    always @(negedge clk) if (srclk1 === 1'b1) n_hi1 <= n_hi1 + 1;

    // ---------------- helpers ----------------
    task automatic go_to_cyc0(input int n);
        for (int i = 0; i < 2000 && cyc0 < n; i++) @(negedge clk);
    endtask

    task automatic wait_fd0(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fd0 === 1'b1) begin
                at = cyc0;
                break;
            end
        end
    endtask

    task automatic wait_fd1(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fd1 === 1'b1) begin
                at = cyc1;
                break;
            end
        end
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_srclk"},  32'(srclk0),   32'd0);
        check({tag, "_rclk"},   32'(rclk0),    32'd0);
        check({tag, "_inrclk"}, 32'(in_rclk0), 32'd0);
        check({tag, "_shldn"},  32'(shldn0),   32'd1);
        check({tag, "_ser"},    32'(so0),      32'd0);
        check({tag, "_sw_reg"}, 32'(sw_reg_c0), 32'd0);
        check({tag, "_sw_st"},  32'(sw_strt0), 32'd0);
        check({tag, "_sw_sel"}, 32'(sw_sel0),  32'd0);
        check({tag, "_valid"},  32'(valid0),   32'd0);
        check({tag, "_fd"},     32'(fd0),      32'd0);
    endtask

    task automatic check_display(input string tag, input logic [30:0] reg_c,
                                 input logic [5:0] op, input logic [11:0] strt,
                                 input logic [11:0] sel);
        check({tag, "_reg_c"}, 32'(disp_reg_c),      32'(reg_c));
        check({tag, "_op"},    32'(disp_v[29:24]),   32'(op));
        check({tag, "_strt"},  32'(disp_v[23:12]),   32'(strt));
        check({tag, "_sel"},   32'(disp_v[11:0]),    32'(sel));
    endtask

    task automatic check_sw0(input string tag, input logic [30:0] reg_c,
                             input logic [11:0] strt, input logic [11:0] sel);
        check({tag, "_sw_reg"}, 32'(sw_reg_c0), 32'(reg_c));
        check({tag, "_sw_st"},  32'(sw_strt0),  32'(strt));
        check({tag, "_sw_sel"}, 32'(sw_sel0),   32'(sel));
        check({tag, "_valid"},  32'(valid0),    32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int at, b_sr, b_r, b_in, b_hi;

        rst0 = 1'b0;
        rst1 = 1'b0;
        pnl_reg_c = 31'h1234_5678;
        pnl_op    = 6'h2A;
        pnl_strt  = 12'hABC;
        pnl_sel   = 12'h123;
        // sw reg_c 7FFF_0001, strt 5A5, sel F0F; discarded bits set to 1s/junk.
        par165[0] = 16'h0001;
        par165[1] = 16'hFFFF;
        par165[2] = 16'h5F0F;
        par165[3] = 16'hC35A;

        // Reset held for 5 cycles: reset values, no srclk edges.
        repeat (2) @(negedge clk);
        b_sr = n_srclk0;
        repeat (5) @(negedge clk);
        check_reset0("rst");
        check("rst_no_srclk", 32'(n_srclk0 - b_sr), 32'd0);

        // Frame 1: release reset; this negedge half is cycle 0.
        rst0 = 1'b1;
        b_sr = n_srclk0; b_r = n_rclk0; b_in = n_inclk0;
        go_to_cyc0(144);
        check("f1_pre_valid", 32'(valid0), 32'd0);
        check("f1_pre_fd",    32'(fd0),    32'd0);
        // Frame-2 stimulus, applied before the next LOAD entry.
        pnl_reg_c = 31'h7FFF_FFFF;
        pnl_op    = 6'h01;
        pnl_strt  = 12'hFFF;
        pnl_sel   = 12'h000;
        par165[0] = 16'h8000;
        par165[1] = 16'h4000;
        par165[2] = 16'h1001;
        par165[3] = 16'hFF80;
        wait_fd0(10, at);
        check("f1_fd_cycle", 32'(at), 32'd145);
        check_sw0("f1", 31'h7FFF_0001, 12'h5A5, 12'hF0F);
        check_display("f1", 31'h1234_5678, 6'h2A, 12'hABC, 12'h123);
        check("f1_srclk_edges", 32'(n_srclk0 - b_sr), 32'd16);
        check("f1_inclk_edges", 32'(n_inclk0 - b_in), 32'd16);
        check("f1_rclk_edges",  32'(n_rclk0 - b_r),   32'd1);
        check("f1_rclk_after_srclk", 32'(srclk_at_rclk0 - b_sr), 32'd16);
        b_sr = n_srclk0; b_r = n_rclk0; b_in = n_inclk0;
        @(negedge clk);
        check("f1_fd_pulse", 32'(fd0), 32'd0);

        // Frame 2: op changes during SHIFT bit 5; must not show until frame 3.
        go_to_cyc0(195);
        pnl_op = 6'h3F;
        go_to_cyc0(288);
        check("f2_hold_sw_reg", 32'(sw_reg_c0), 32'h7FFF_0001);
        check("f2_hold_fd",     32'(fd0),       32'd0);
        wait_fd0(10, at);
        check("f2_fd_cycle", 32'(at), 32'd289);
        check_sw0("f2", 31'h4000_8000, 12'h801, 12'h001);
        check_display("f2", 31'h7FFF_FFFF, 6'h01, 12'hFFF, 12'h000);
        check("f2_srclk_edges", 32'(n_srclk0 - b_sr), 32'd16);
        check("f2_rclk_edges",  32'(n_rclk0 - b_r),   32'd1);

        // Frame 3 shows the new op; frame-4 switch data loaded meanwhile.
        go_to_cyc0(300);
        par165[0] = 16'h5555;
        par165[1] = 16'hAAAA;
        par165[2] = 16'h6999;
        par165[3] = 16'hFF3C;
        wait_fd0(200, at);
        check("f3_fd_cycle", 32'(at), 32'd433);
        check_display("f3", 31'h7FFF_FFFF, 6'h3F, 12'hFFF, 12'h000);
        check_sw0("f3", 31'h4000_8000, 12'h801, 12'h001);

        // Reset during SHIFT bit 7 of frame 4.
        go_to_cyc0(499);
        rst0 = 1'b0;
        @(negedge clk);
        check_reset0("midrst");
        @(negedge clk);
        rst0 = 1'b1;
        wait_fd0(200, at);
        check("postrst_fd_cycle", 32'(at), 32'd145);
        check_sw0("postrst", 31'h2AAA_5555, 12'h3C6, 12'h999);
        check_display("postrst", 31'h7FFF_FFFF, 6'h3F, 12'hFFF, 12'h000);

        // CLK_DIV = 1: 36-cycle frames, 1-cycle srclk high phases.
        rst1 = 1'b1;
        b_sr = n_srclk1; b_hi = n_hi1;
        wait_fd1(100, at);
        check("d1_fd_cycle", 32'(at), 32'd37);
        check("d1_srclk_edges", 32'(n_srclk1 - b_sr), 32'd16);
        check("d1_srclk_high",  32'(n_hi1 - b_hi),    32'd16);
        check("d1_sw_reg", 32'(sw_reg_c1), 32'h0000_FFFF);
        check("d1_sw_st",  32'(sw_strt1),  32'h00F);
        check("d1_sw_sel", 32'(sw_sel1),   32'hFFF);
        check("d1_valid",  32'(valid1),    32'd1);
        b_sr = n_srclk1; b_hi = n_hi1;
        wait_fd1(100, at);
        check("d1_fd_cycle2", 32'(at), 32'd73);
        check("d1_srclk_edges2", 32'(n_srclk1 - b_sr), 32'd16);
        check("d1_srclk_high2",  32'(n_hi1 - b_hi),    32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
